// File: rtl/multdiv_ctrl.sv
// Execute-stage sequencer for an external multi-cycle multiplier/divider: accepts
// mul/div, pulses the unit, stalls the pipe, then issues a single register write.
module multdiv_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] insn,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic [31:0] md_result,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam logic [5:0]  TMO       = 6'(TIMEOUT);
  localparam logic [4:0]  EXC_RD    = 5'd30;
  localparam logic [31:0] EXC_MUL   = 32'd4;
  localparam logic [31:0] EXC_DIV   = 32'd5;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        is_mul, is_div, accept;
  logic        op_div;
  logic [4:0]  rd_q;
  logic        exc_q;
  logic [5:0]  cnt, cnt_inc;
  logic        wait_end, end_exc;
  logic        stall_c;
  logic        unused_insn_bits;

  assign unused_insn_bits = ^{insn[21:7], insn[1:0]};

  assign is_mul   = (insn[31:27] == 5'b00000) && (insn[6:2] == 5'b00110);
  assign is_div   = (insn[31:27] == 5'b00000) && (insn[6:2] == 5'b00111);
  assign accept   = (state == IDLE) && valid_in && (is_mul || is_div);
  assign cnt_inc  = cnt + 6'd1;
  // A result arriving on the last allowed WAIT cycle still wins over the timeout.
  assign wait_end = (state == WAIT) && (md_ready || (cnt_inc == TMO));
  assign end_exc  = md_ready ? md_exception : 1'b1;
  // Combinational stall is gated so every output reads 0 while reset is held.
  assign stall    = stall_c && reset;

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    wb_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_c   = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        stall_c   = 1'b1;
        ctrl_MULT = ~op_div;
        ctrl_DIV  = op_div;
        state_nxt = WAIT;
      end
      WAIT: begin
        stall_c = 1'b1;
        if (wait_end) state_nxt = DONE;
      end
      DONE: begin
        wb_valid  = exc_q || (rd_q != 5'd0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      md_opA  <= 32'd0;
      md_opB  <= 32'd0;
      op_div  <= 1'b0;
      rd_q    <= 5'd0;
      exc_q   <= 1'b0;
      wb_rd   <= 5'd0;
      wb_data <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        md_opA <= operandA;
        md_opB <= operandB;
        rd_q   <= insn[26:22];
        op_div <= is_div;
      end
      if (state == START) cnt <= 6'd0;
      if (state == WAIT) cnt <= cnt_inc;
      // Write-back values are formed on the way into DONE and then held.
      if (wait_end) begin
        exc_q   <= end_exc;
        wb_rd   <= end_exc ? EXC_RD : rd_q;
        wb_data <= end_exc ? (op_div ? EXC_DIV : EXC_MUL) : md_result;
      end
    end
  end

endmodule
